// File: rtl/oka_47bit_seq_if.sv
// rtl/oka_47bit_seq_if.sv - operand/result handshake bundle for the sequential 47-bit GF(2) multiplier
interface oka_47bit_seq_if #(
    parameter int N = 47
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-2:0]   y;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/oka_47bit_seq.sv
// rtl/oka_47bit_seq.sv - sequential 47-bit carry-less multiplier sharing one 24-bit OKA core
module OKA_24bit (
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [46:0] p
);
    function automatic logic [22:0] clmul12(input logic [11:0] x, input logic [11:0] z);
        logic [22:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            if (z[i]) r = r ^ ({11'b0, x} << i);
        end
        return r;
    endfunction

    function automatic logic [46:0] spread23(input logic [22:0] v);
        logic [46:0] r;
        r = '0;
        for (int i = 0; i < 23; i++) r[2*i] = v[i];
        return r;
    endfunction

    logic [11:0] a0, a1, b0, b1;
    logic [22:0] q1, q2, q3, qm;

    // even/odd split of the 24-bit operands; a 24-bit width has no odd tail
    always_comb begin
        a0 = '0;
        a1 = '0;
        b0 = '0;
        b1 = '0;
        for (int i = 0; i < 12; i++) begin
            a0[i] = a[2*i];
            a1[i] = a[2*i+1];
            b0[i] = b[2*i];
            b1[i] = b[2*i+1];
        end
    end

    assign q1 = clmul12(a0, b0);
    assign q2 = clmul12(a1, b1);
    assign q3 = clmul12(a0 ^ a1, b0 ^ b1);
    assign qm = q3 ^ q1 ^ q2;
    assign p  = spread23(q1) ^ (spread23(q2) << 2) ^ (spread23(qm) << 1);
endmodule

module oka_47bit_seq #(
    parameter int N = 47,
    parameter int H = (N + 1) / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    oka_47bit_seq_if.slave        bus
);
    localparam int P  = 2*H - 1;
    localparam int W  = 2*N - 1;
    localparam int SW = 2*P + 2;

    typedef enum logic [2:0] {IDLE, M1, M2, M3, OUT} state_t;

    state_t         state;
    logic [N-1:0]   a_q, b_q;
    logic [P-1:0]   p1_q, p2_q;
    logic [W-1:0]   y_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [H-1:0]   a0, a1, b0, b1;
    logic [H-1:0]   core_a, core_b;
    logic [P-1:0]   core_p;
    logic [P-1:0]   mid;
    logic [SW-1:0]  y_full;
    logic           accept;

    function automatic logic [SW-1:0] spread(input logic [P-1:0] v);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < P; i++) r[2*i] = v[i];
        return r;
    endfunction

    // even/odd split of the latched operands; the odd half has one fewer coefficient
    always_comb begin
        a0 = '0;
        a1 = '0;
        b0 = '0;
        b1 = '0;
        for (int i = 0; i < H; i++) begin
            a0[i] = a_q[2*i];
            b0[i] = b_q[2*i];
        end
        for (int i = 0; i < H - 1; i++) begin
            a1[i] = a_q[2*i+1];
            b1[i] = b_q[2*i+1];
        end
    end

    // state-selected operand mux in front of the single shared core
    always_comb begin
        core_a = a0;
        core_b = b0;
        case (state)
            M2: begin
                core_a = a1;
                core_b = b1;
            end
            M3: begin
                core_a = a0 ^ a1;
                core_b = b0 ^ b1;
            end
            default: begin
                core_a = a0;
                core_b = b0;
            end
        endcase
    end

    OKA_24bit u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    // in M3 the core output is P3 directly, so the middle term needs no register
    assign mid    = core_p ^ p1_q ^ p2_q;
    assign y_full = spread(p1_q) ^ (spread(p2_q) << 2) ^ (spread(mid) << 1);

    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.in_ready = (state == IDLE) | ((state == OUT) & bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.y         = y_q;

    // sequencing FSM: three core cycles, then hold the product until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        state  <= M1;
                        busy_q <= 1'b1;
                    end
                end
                M1: begin
                    p1_q  <= core_p;
                    state <= M2;
                end
                M2: begin
                    p2_q  <= core_p;
                    state <= M3;
                end
                M3: begin
                    y_q         <= y_full[W-1:0];
                    out_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            a_q   <= bus.a;
                            b_q   <= bus.b;
                            state <= M1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_oka_47bit_seq.sv
// tb/tb_oka_47bit_seq.sv - directed and random checks for oka_47bit_seq
module tb_oka_47bit_seq;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    oka_47bit_seq_if #(.N(47)) bus ();

    oka_47bit_seq #(.N(47)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [92:0] clmul(input logic [46:0] x, input logic [46:0] z);
        logic [92:0] r;
        r = '0;
        for (int i = 0; i < 47; i++) begin
            if (z[i]) r = r ^ ({46'b0, x} << i);
        end
        return r;
    endfunction

    function automatic logic [46:0] rand47();
        return {$urandom, $urandom} & 64'h0000_7FFF_FFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [92:0] obs, input logic [92:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_mult(input logic [46:0] x, input logic [46:0] z,
                           output logic [92:0] res, output int lat, output int nbusy);
        int n;
        @(negedge clk);
        bus.a = x;
        bus.b = z;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = -1;
        nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) nbusy++;
        end while (!bus.out_valid && lat < 10);
        res = bus.y;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        if (bus.busy) nbusy++;
    endtask

    logic [92:0] res;
    logic [92:0] exp_v;
    logic [92:0] expq[$];
    logic [46:0] ra, rb;
    int          lat, nb, last_acc, nacc, n;
    logic        acc;

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 93'(bus.out_valid), 93'(0));
        check("rst_busy", 93'(bus.busy), 93'(0));
        check("rst_y", bus.y, 93'(0));
        check("rst_in_ready", 93'(bus.in_ready), 93'(1));

        do_mult(47'd1, 47'd1, res, lat, nb);
        check("one_y", res, 93'd1);
        check("one_latency", 93'(lat), 93'd3);
        check("one_busy_cycles", 93'(nb), 93'd4);

        do_mult(47'h4000_0000_0000, 47'h4000_0000_0000, res, lat, nb);
        check("top_bit", res, 93'h1000_0000_0000_0000_0000_0000);
        do_mult(47'd2, 47'h2000_0000_0000, res, lat, nb);
        check("x_times_x45", res, 93'h4000_0000_0000);
        do_mult(47'h7, 47'h7, res, lat, nb);
        check("seven_sq", res, 93'h15);
        do_mult(47'h3, 47'h3, res, lat, nb);
        check("three_sq", res, 93'h5);
        do_mult(47'h7FFF_FFFF_FFFF, 47'd1, res, lat, nb);
        check("ones_times_one", res, 93'h7FFF_FFFF_FFFF);

        for (int i = 0; i < 2000; i++) begin
            ra = rand47();
            rb = rand47();
            do_mult(ra, rb, res, lat, nb);
            check("random", res, clmul(ra, rb));
        end

        // backpressure: leave the product waiting for 10 cycles
        ra = 47'h1234_5678_9ABC;
        rb = 47'h0000_0000_0055;
        exp_v = clmul(ra, rb);
        @(negedge clk);
        bus.a = ra;
        bus.b = rb;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        ra = 47'h0ABC_DEF0_1357;
        rb = 47'h5555_5555_5555;
        bus.a = ra;
        bus.b = rb;
        repeat (4) @(negedge clk);
        check("bp_valid_rise", 93'(bus.out_valid), 93'(1));
        check("bp_first_y", bus.y, exp_v);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stall_y", bus.y, exp_v);
            check("bp_stall_valid", 93'(bus.out_valid), 93'(1));
            check("bp_stall_in_ready", 93'(bus.in_ready), 93'(0));
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_in_ready", 93'(bus.in_ready), 93'(1));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_after_valid", 93'(bus.out_valid), 93'(0));
        check("bp_after_busy", 93'(bus.busy), 93'(1));
        repeat (3) @(negedge clk);
        check("bp_second_valid", 93'(bus.out_valid), 93'(1));
        check("bp_second_y", bus.y, clmul(ra, rb));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // streaming with out_ready tied high
        ra = rand47();
        rb = rand47();
        @(negedge clk);
        bus.a = ra;
        bus.b = rb;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        nacc = 0;
        last_acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (c != 0) @(negedge clk);
            if (bus.out_valid) begin
                if (expq.size() == 0) check("stream_extra", 93'(1), 93'(0));
                else check("stream_y", bus.y, expq.pop_front());
            end
            acc = bus.in_ready;
            if (acc) begin
                if (nacc > 0) check("stream_gap", 93'(c - last_acc), 93'd4);
                last_acc = c;
                nacc++;
                expq.push_back(clmul(ra, rb));
            end
            @(posedge clk);
            #1;
            if (acc) begin
                ra = rand47();
                rb = rand47();
                bus.a = ra;
                bus.b = rb;
            end
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (expq.size() > 0 && n < 20) begin
            @(negedge clk);
            if (bus.out_valid) check("stream_drain_y", bus.y, expq.pop_front());
            n++;
        end
        check("stream_drained", 93'(expq.size()), 93'(0));
        check("stream_accepts", 93'(nacc), 93'd10);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // reset while in M2 discards the in-flight product
        @(negedge clk);
        bus.a = 47'h7FFF_FFFF_FFFF;
        bus.b = 47'h3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstm2_busy", 93'(bus.busy), 93'(0));
        check("rstm2_out_valid", 93'(bus.out_valid), 93'(0));
        check("rstm2_y", bus.y, 93'(0));
        check("rstm2_in_ready", 93'(bus.in_ready), 93'(1));
        do_mult(47'h3, 47'h3, res, lat, nb);
        check("rstm2_next_y", res, 93'h5);

        // reset and in_valid together: nothing accepted
        @(negedge clk);
        rst = 1'b1;
        bus.a = 47'h5;
        bus.b = 47'h5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_wins_busy", 93'(bus.busy), 93'(0));
        repeat (4) @(negedge clk);
        check("rst_wins_no_result", 93'(bus.out_valid), 93'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
